instruction_fetch_decode: RTL
=============================

Name: instruction_fetch_decode

Overview:
- Front-end partner of the next-PC unit.
- Takes the current PC and fetches the instruction word over a stalling memory read interface.
- Latches the word and decodes it into the jump/branch strobes and fields that the next-PC unit consumes: J…BNE, I_intermidiete, J_intermidiete, and rs/rt register addresses.
- Drives the two-phase `state` (0 = fetch, 1 = execute) and the `STALL` signal for the rest of the datapath.

Parameters:
- TIMEOUT_CYCLES, default 0: maximum consecutive waitrequest cycles before a fetch error; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- PC_in  in  32  current PC from the next-PC unit; stable while state=0.
- instr_address  out  32  memory read address.
- instr_read  out  1  memory read request.
- instr_waitrequest  in  1  memory is not ready; hold the request.
- instr_readdata  in  32  instruction word; valid on the edge where read=1 and waitrequest=0.
- STALL  out  1  fetch pending.
- state  out  1  0 = fetch phase, 1 = execute phase.
- fetch_error  out  1  sticky error flag; cleared only by reset.
- rs_addr  out  5  IR[25:21].
- rt_addr  out  5  IR[20:16].
- I_intermidiete  out  16  IR[15:0].
- J_intermidiete  out  26  IR[25:0].
- J JAL JR JALR BEQ BNE BGEZ BGEZAL BGTZ BLEZ BLTZ BLTZAL  out  1 each  decoded control strobes.

Behaviour:
- FSM states: FETCH, EXEC, HALT. Internal registers: IR (32 bits) and wait_cnt.
- Reset:
  - On a clock edge with rst=1: FSM goes to FETCH, IR=0 (NOP), wait_cnt=0, fetch_error=0.
  - Output values after reset: state=0, all strobes 0, fields 0.
  - rst overrides every other condition, including mid-wait. readdata presented on that edge is discarded.
- FETCH:
  - Outputs: state=0, instr_read=1, instr_address=PC_in (combinational).
  - STALL=instr_waitrequest.
  - If PC_in[1:0]≠0: instr_read=0 and the next state is HALT with fetch_error set.
  - If waitrequest=0 at the edge: IR<=readdata, wait_cnt<=0, next state EXEC.
  - If waitrequest=1: stay in FETCH and increment wait_cnt.
  - If TIMEOUT_CYCLES≠0 and wait_cnt reaches TIMEOUT_CYCLES-1 while waitrequest=1: next state HALT, fetch_error=1.
- EXEC:
  - Lasts exactly one cycle: state=1, instr_read=0, STALL=0.
  - Decoded strobes are valid only in this cycle; next state is FETCH.
- HALT: state=0, instr_read=0, STALL=1, all strobes 0. Exited only by rst.
- Strobes are forced to 0 outside EXEC. rs_addr, rt_addr, I_intermidiete and J_intermidiete come from IR and hold until the next IR load.
- Latency: a zero-wait fetch takes 2 cycles per instruction (FETCH, EXEC). Each wait cycle adds 1.
- Decode uses opcode=IR[31:26], funct=IR[5:0], rt=IR[20:16]. At most one strobe is high:
  - 000010 → J
  - 000011 → JAL
  - 000000 with funct 001000 → JR
  - 000000 with funct 001001 → JALR
  - 000100 → BEQ
  - 000101 → BNE
  - 000110 with rt=0 → BLEZ
  - 000111 with rt=0 → BGTZ
  - 000001 (REGIMM), selected by rt: 00000 BLTZ, 00001 BGEZ, 10000 BLTZAL, 10001 BGEZAL
  - Anything else: no strobe. Non-control instructions pass through as fields only.
- readdata is used verbatim; no byte swap.

Test Plan:
- Zero-wait J fetch:
  - Stimulus: rst pulse, PC_in=0x0, memory returns 0x0800000A with waitrequest=0.
  - Cycle 1: read=1, address=0, state=0.
  - Cycle 2: state=1, J=1, J_intermidiete=10.
  - Cycle 3: back in FETCH.
- Wait states on BEQ:
  - Stimulus: PC_in=0x10, waitrequest high for 3 cycles, readdata=0x1085FFFE.
  - STALL=1 and read held with address 0x10 for 3 cycles.
  - Then EXEC with BEQ=1, rs=4, rt=5, I=0xFFFE.
- REGIMM decode:
  - Stimulus: words 0x04110004, 0x04100004, 0x04010004, 0x04000004.
  - Response: BGEZAL, BLTZAL, BGEZ, BLTZ respectively; each strobe high only in its EXEC cycle.
- JR/JALR vs ADDU:
  - Stimulus: 0x03E00008, 0x0080F809, 0x00851021.
  - Response: JR=1, then JALR=1, then all strobes 0 with rs=4, rt=5.
- Reset mid-wait:
  - Stimulus: rst asserted on the 2nd waitrequest cycle, readdata=0x08000001 on the same edge.
  - Response: next cycle read=1 (new FETCH), IR=0, no strobe fires.
- Errors:
  - Stimulus: PC_in=0x6.
  - Response: read never asserted, fetch_error=1, STALL=1 until rst.
  - Stimulus: TIMEOUT_CYCLES=4 with waitrequest held high.
  - Response: fetch_error=1 after 4 FETCH cycles; read drops.

Source files
------------

// File: rtl/instruction_fetch_decode_if.sv
// Instruction memory read bus between the fetch/decode stage and instruction memory.
// The fetch unit is the master: it drives the address and the read request, and the
// memory answers with waitrequest and readdata.
interface instruction_fetch_decode_if;
   logic [31:0] instr_address;
   logic        instr_read;
   logic        instr_waitrequest;
   logic [31:0] instr_readdata;

   modport master (
      output instr_address,
      output instr_read,
      input  instr_waitrequest,
      input  instr_readdata
   );

   modport slave (
      input  instr_address,
      input  instr_read,
      output instr_waitrequest,
      output instr_readdata
   );
endinterface

// File: rtl/instruction_fetch_decode.sv
// Instruction fetch and decode front end.
// Fetches the word at PC_in over a stalling read bus, latches it into IR, and decodes
// it into the jump/branch strobes and immediate/register fields used by the next-PC
// unit. It runs a two-phase FETCH/EXEC cycle and drops into HALT on a misaligned PC
// or a memory timeout, leaving HALT only through reset.
module instruction_fetch_decode #(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC_in,
   instruction_fetch_decode_if.master bus,
   output logic        STALL,
   output logic        state,
   output logic        fetch_error,
   output logic [4:0]  rs_addr,
   output logic [4:0]  rt_addr,
   output logic [15:0] I_intermidiete,
   output logic [25:0] J_intermidiete,
   output logic        J,
   output logic        JAL,
   output logic        JR,
   output logic        JALR,
   output logic        BEQ,
   output logic        BNE,
   output logic        BGEZ,
   output logic        BGEZAL,
   output logic        BGTZ,
   output logic        BLEZ,
   output logic        BLTZ,
   output logic        BLTZAL
);

   // FSM encoding
   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] EXEC  = 2'd1;
   localparam logic [1:0] HALT  = 2'd2;

   // Opcodes and function codes that produce a control strobe
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BLEZ    = 6'b000110;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;
   localparam logic [4:0] RT_BLTZ    = 5'b00000;
   localparam logic [4:0] RT_BGEZ    = 5'b00001;
   localparam logic [4:0] RT_BLTZAL  = 5'b10000;
   localparam logic [4:0] RT_BGEZAL  = 5'b10001;

   // Wait counter only needs to reach TIMEOUT_CYCLES-1; with the timeout disabled it
   // is a single free-running bit that nothing looks at.
   localparam int unsigned   CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             fetch_error_q, fetch_error_d;

   logic             in_fetch;
   logic             in_exec;
   logic             pc_misaligned;
   logic             timeout_hit;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [4:0]       rt_field;

   assign in_fetch      = (state_q == FETCH);
   assign in_exec       = (state_q == EXEC);
   assign pc_misaligned = (PC_in[1:0] != 2'b00);
   assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_LAST);

   assign opcode   = ir_q[31:26];
   assign funct    = ir_q[5:0];
   assign rt_field = ir_q[20:16];

   // Next-state logic: fetch handshake, timeout and error capture
   always_comb begin
      // NOTE: every variable gets a default before the case so no latch is inferred.
      state_d       = state_q;
      ir_d          = ir_q;
      wait_cnt_d    = wait_cnt_q;
      fetch_error_d = fetch_error_q;
      case (state_q)
         FETCH: begin
            if (pc_misaligned) begin
               state_d       = HALT;
               fetch_error_d = 1'b1;
            end else if (!bus.instr_waitrequest) begin
               ir_d       = bus.instr_readdata;
               wait_cnt_d = '0;
               state_d    = EXEC;
            end else if (timeout_hit) begin
               state_d       = HALT;
               fetch_error_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         EXEC:    state_d = FETCH;
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   // State registers with synchronous reset; IR resets to a NOP so fields read 0
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q       <= FETCH;
         ir_q          <= '0;
         wait_cnt_q    <= '0;
         fetch_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         wait_cnt_q    <= wait_cnt_d;
         fetch_error_q <= fetch_error_d;
      end
   end

   // Bus and phase outputs; a misaligned PC never reaches the memory
   always_comb begin
      bus.instr_address = PC_in;
      bus.instr_read    = in_fetch && !pc_misaligned;
      state             = in_exec;
      fetch_error       = fetch_error_q;
      STALL             = 1'b0;
      if (in_fetch) begin
         STALL = bus.instr_waitrequest;
      end else if (state_q == HALT) begin
         STALL = 1'b1;
      end
   end

   // Register and immediate fields follow IR and hold until the next load
   assign rs_addr        = ir_q[25:21];
   assign rt_addr        = ir_q[20:16];
   assign I_intermidiete = ir_q[15:0];
   assign J_intermidiete = ir_q[25:0];

   // Control decode, gated so strobes are only visible during the EXEC cycle
   always_comb begin
      J      = 1'b0;
      JAL    = 1'b0;
      JR     = 1'b0;
      JALR   = 1'b0;
      BEQ    = 1'b0;
      BNE    = 1'b0;
      BGEZ   = 1'b0;
      BGEZAL = 1'b0;
      BGTZ   = 1'b0;
      BLEZ   = 1'b0;
      BLTZ   = 1'b0;
      BLTZAL = 1'b0;
      if (in_exec) begin
         case (opcode)
            OP_J:    J   = 1'b1;
            OP_JAL:  JAL = 1'b1;
            OP_BEQ:  BEQ = 1'b1;
            OP_BNE:  BNE = 1'b1;
            OP_BLEZ: BLEZ = (rt_field == 5'd0);
            OP_BGTZ: BGTZ = (rt_field == 5'd0);
            OP_SPECIAL: begin
               JR   = (funct == FN_JR);
               JALR = (funct == FN_JALR);
            end
            OP_REGIMM: begin
               case (rt_field)
                  RT_BLTZ:   BLTZ   = 1'b1;
                  RT_BGEZ:   BGEZ   = 1'b1;
                  RT_BLTZAL: BLTZAL = 1'b1;
                  RT_BGEZAL: BGEZAL = 1'b1;
                  default:   ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule
